cme_ip_rx_frame_wr_v3: RTL and testbench
========================================

// Module: cme_ip_rx_frame_wr_v3
// PURPOSE
//  Upstream feeder of the 768x32 RX dual-port buffer. Takes the MAC RX byte stream,
//  packs bytes little-endian into 32-bit words and writes each frame into the buffer,
//  which is used as a circular ring. A 1-word length header precedes each frame.
//  Commits complete, good frames to the EMIF reader through wr_ptr.
//  Drops overflowing, oversize and aborted frames without disturbing committed data.
// PARAMETERS
//  DEPTH_WORDS  768   ring size in 32-bit words; wrap from DEPTH_WORDS-1 to 0
//  AW           10    word address width
//  MAX_BYTES    1536  largest accepted frame length in bytes
// PORTS
//  clk        in   1   single clock: MAC RX clock and buffer write clock
//  rst_n      in   1   asynchronous, active-low reset
//  rx_valid   in   1   byte strobe; rx_data, rx_sof, rx_eof and rx_err are valid only while it is high
//  rx_data    in   8   frame byte
//  rx_sof     in   1   first byte of frame
//  rx_eof     in   1   last byte of frame
//  rx_err     in   1   frame error (CRC/PHY); sampled with rx_eof
//  rd_ptr     in   AW  reader's next-unread word address, already in the clk domain
//  ram_cew    out  1   buffer write enable
//  ram_aw     out  AW  buffer write word address
//  ram_dw     out  32  buffer write data
//  wr_ptr     out  AW  committed write pointer, one past the last committed word
//  frm_done   out  1   1-cycle pulse when a frame is committed
//  frm_len    out  11  byte length of the last committed frame
//  drop_cnt   out  16  count of dropped frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, packing register cleared. Reset mid-frame discards the partial frame.
//  Ring state: empty when wr_ptr==rd_ptr. A write to address a is legal only while a != rd_ptr.
//  Packing: byte k of a word occupies lanes [8k+7:8k]. Unused lanes of the final word are 0.
//  A RAM write (ram_cew=1 for one cycle) is issued in the cycle after a byte that fills lane 3 or carries eof.
//  FSM states:
//   IDLE : rx_valid&rx_sof -> start=wr_ptr, data pointer dp=start+1 (wrapped), byte count=1.
//          If start+1==rd_ptr -> DROP. Otherwise -> DATA.
//          rx_valid without rx_sof is ignored.
//   DATA : accepts bytes. Before each word write, if dp==rd_ptr -> DROP (overflow).
//          Byte count > MAX_BYTES -> DROP.
//          rx_sof while in DATA (missing eof) -> drop the old frame, count it, and restart the new frame as in IDLE.
//          rx_eof -> FLUSH. The final word is written in this cycle.
//   FLUSH: one cycle. The last data word is written here if it was not written earlier. -> HDR.
//   HDR  : writes header at addr start.
//          Header: [10:0]=byte length, [16]=error flag, all other bits 0.
//          -> COMMIT.
//   COMMIT: wr_ptr<=dp (wrapped), frm_done=1, frm_len=length -> IDLE.
//   DROP : discards bytes until rx_eof, then -> IDLE. drop_cnt increments once, on entry.
//          wr_ptr is unchanged. Words already written stay in memory but are never committed.
//  Latency: eof byte at cycle N -> final data write at N+1, header write at N+2, wr_ptr/frm_done at N+3.
//  rx_sof arriving in FLUSH/HDR/COMMIT violates the inter-frame gap. That new frame is dropped via DROP and counted.
//  Address arithmetic: addr+1 wraps to 0 when addr==DEPTH_WORDS-1. Values >= DEPTH_WORDS never appear on ram_aw.
//  Words per frame = ceil(len/4)+1. rd_ptr may change on any cycle; the check uses its current value.
// CONFIGURATION
//  RX_ERR_FRAME_KEEP_EN defined: frames with rx_err at eof are committed with header bit 16 = 1.
//  RX_ERR_FRAME_KEEP_EN undefined: such frames are dropped, drop_cnt increments, no frm_done is produced, and header bit 16 is always 0.
// TESTING
//  1. rd=wr=0, 64-byte frame with bytes 0x00..0x3F:
//     data word at addr 1 = 32'h03020100 ... addr 16 = 32'h3F3E3D3C.
//     Header at addr 0 = 32'h00000040. wr_ptr=17, frm_done one pulse, frm_len=64.
//  2. 61-byte frame from wr=0: addr 16 = 32'h0000003C. Header = 32'h0000003D. wr_ptr=17.
//  3. Wrap: wr=rd=760, 64-byte frame: header at 760, data at 761..767 then 0..8. wr_ptr=9.
//  4. Overflow: wr=0, rd=10, 64-byte frame: words written to 1..9 only, no write to addr 10.
//     drop_cnt=1, wr_ptr stays 0, no frm_done. A following 16-byte frame after rd moves to 0 commits normally.
//  5. 64-byte frame with rx_err at eof: without macro -> drop_cnt+1 and wr_ptr unchanged.
//     With macro -> header = 32'h00010040 and frame committed.
//  6. 1537-byte frame -> dropped, drop_cnt+1. Then assert rst_n=0 mid-frame:
//     all outputs 0 at once, next frame commits from addr 0.

Source files
------------

// File: rtl/cme_ip_rx_frame_wr_v3.sv
// RX frame writer: packs MAC bytes into 32-bit words, writes length-headed frames into a ring buffer.
// Optional macro RX_ERR_FRAME_KEEP_EN: commit errored frames with header bit 16 set instead of dropping them.
module cme_ip_rx_frame_wr_v3 #(
  parameter int DEPTH_WORDS = 768,
  parameter int AW          = 10,
  parameter int MAX_BYTES   = 1536
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_sof,
  input  logic          rx_eof,
  input  logic          rx_err,
  input  logic [AW-1:0] rd_ptr,
  output logic          ram_cew,
  output logic [AW-1:0] ram_aw,
  output logic [31:0]   ram_dw,
  output logic [AW-1:0] wr_ptr,
  output logic          frm_done,
  output logic [10:0]   frm_len,
  output logic [15:0]   drop_cnt
);

`ifdef RX_ERR_FRAME_KEEP_EN
  localparam logic ERR_KEEP = 1'b1;
`else
  localparam logic ERR_KEEP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, DATA, FLUSH, HDR, COMMIT, DROP} state_t;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH_WORDS - 1)) ? '0 : a + 1'b1;
  endfunction

  state_t        state, state_n;
  logic [AW-1:0] start, start_n, dp, dp_n;
  logic [11:0]   cnt, cnt_n;
  logic [31:0]   word, word_n;
  logic          err_q, err_n, pend, pend_n, pend_eof, pend_eof_n;
  logic          cew_n, done_n;
  logic [AW-1:0] aw_n, wr_ptr_n;
  logic [31:0]   dw_n;
  logic [10:0]   len_n;
  logic [1:0]    drop_add;
  logic [31:0]   base_word, lane_word;
  logic [11:0]   base_cnt, cnt_inc;
  logic [AW-1:0] base_dp;
  logic          word_full, pend_any, eof_any;
  logic [16:0]   drop_sum;

  // Bytes (and sof/eof/err) are only looked at in cycles where rx_valid is high; there is no back-pressure.
  always_comb begin
    state_n    = state;
    start_n    = start;
    dp_n       = dp;
    cnt_n      = cnt;
    word_n     = word;
    err_n      = err_q;
    pend_n     = pend;
    pend_eof_n = pend_eof;
    cew_n      = 1'b0;
    aw_n       = ram_aw;
    dw_n       = ram_dw;
    wr_ptr_n   = wr_ptr;
    done_n     = 1'b0;
    len_n      = frm_len;
    drop_add   = 2'd0;

    // A sof byte always starts from a fresh packing context at wr_ptr+1.
    base_word = '0;
    base_cnt  = '0;
    base_dp   = addr_inc(wr_ptr);
    if (state == DATA && !rx_sof) begin
      base_word = word;
      base_cnt  = cnt;
      base_dp   = dp;
    end
    lane_word = base_word | ({24'b0, rx_data} << {base_cnt[1:0], 3'b000});
    cnt_inc   = base_cnt + 12'd1;
    word_full = (base_cnt[1:0] == 2'd3) || rx_eof;

    pend_any = pend | (rx_valid & rx_sof);
    eof_any  = pend_eof | (rx_valid & rx_eof & pend_any);

    case (state)
      IDLE, DATA: begin
        if (rx_valid && (rx_sof || state == DATA)) begin
          if (state == DATA && rx_sof) drop_add = 2'd1;
          if (rx_sof) start_n = wr_ptr;
          if ((word_full && base_dp == rd_ptr) || (rx_sof && base_dp == rd_ptr) ||
              (cnt_inc > 12'(MAX_BYTES)) || (rx_eof && rx_err && !ERR_KEEP)) begin
            drop_add = drop_add + 2'd1;
            state_n  = rx_eof ? IDLE : DROP;
          end else begin
            cnt_n  = cnt_inc;
            word_n = word_full ? '0 : lane_word;
            dp_n   = base_dp;
            err_n  = rx_err & rx_eof;
            if (word_full) begin
              cew_n = 1'b1;
              aw_n  = base_dp;
              dw_n  = lane_word;
              dp_n  = addr_inc(base_dp);
            end
            state_n = rx_eof ? FLUSH : DATA;
          end
        end
      end
      FLUSH: begin
        cew_n      = 1'b1;
        aw_n       = start;
        dw_n       = {15'b0, err_q & ERR_KEEP, 5'b0, cnt[10:0]};
        pend_n     = pend_any;
        pend_eof_n = eof_any;
        state_n    = HDR;
      end
      HDR: begin
        wr_ptr_n   = dp;
        done_n     = 1'b1;
        len_n      = cnt[10:0];
        pend_n     = pend_any;
        pend_eof_n = eof_any;
        state_n    = COMMIT;
      end
      COMMIT: begin
        // A sof seen during the commit tail is a frame we could not start; drop it.
        pend_n     = 1'b0;
        pend_eof_n = 1'b0;
        state_n    = IDLE;
        if (pend_any) begin
          drop_add = 2'd1;
          state_n  = eof_any ? IDLE : DROP;
        end
      end
      DROP: begin
        if (rx_valid && rx_eof) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign drop_sum = {1'b0, drop_cnt} + {15'b0, drop_add};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start    <= '0;
      dp       <= '0;
      cnt      <= '0;
      word     <= '0;
      err_q    <= 1'b0;
      pend     <= 1'b0;
      pend_eof <= 1'b0;
      ram_cew  <= 1'b0;
      ram_aw   <= '0;
      ram_dw   <= '0;
      wr_ptr   <= '0;
      frm_done <= 1'b0;
      frm_len  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      start    <= start_n;
      dp       <= dp_n;
      cnt      <= cnt_n;
      word     <= word_n;
      err_q    <= err_n;
      pend     <= pend_n;
      pend_eof <= pend_eof_n;
      ram_cew  <= cew_n;
      ram_aw   <= aw_n;
      ram_dw   <= dw_n;
      wr_ptr   <= wr_ptr_n;
      frm_done <= done_n;
      frm_len  <= len_n;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_cme_ip_rx_frame_wr_v3.sv
// Bench for cme_ip_rx_frame_wr_v3: directed and random frames checked against a ring-buffer model.
module tb_cme_ip_rx_frame_wr_v3;

  localparam int DEPTH = 768;
  localparam int MAXB  = 1536;
`ifdef RX_ERR_FRAME_KEEP_EN
  localparam bit KEEP = 1'b1;
`else
  localparam bit KEEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rx_valid, rx_sof, rx_eof, rx_err;
  logic [7:0]  rx_data;
  logic [9:0]  rd_ptr;
  logic        ram_cew, frm_done;
  logic [9:0]  ram_aw, wr_ptr;
  logic [31:0] ram_dw;
  logic [10:0] frm_len;
  logic [15:0] drop_cnt;

  cme_ip_rx_frame_wr_v3 dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err), .rd_ptr(rd_ptr),
    .ram_cew(ram_cew), .ram_aw(ram_aw), .ram_dw(ram_dw), .wr_ptr(wr_ptr),
    .frm_done(frm_done), .frm_len(frm_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0]  fbytes [0:2047];
  logic [31:0] mem_img [0:DEPTH-1];
  bit          wr_seen [0:DEPTH-1];
  int done_cnt = 0, done_cyc = 0, last_eof = 0;
  int m_wr = 0, m_drop = 0, m_done = 0, rd_int = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-port and commit monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_cew) begin
        chk("aw_range", {31'b0, (ram_aw < 10'd768)}, 32'd1);
        if (ram_aw < 10'd768) begin
          mem_img[ram_aw] = ram_dw;
          wr_seen[ram_aw] = 1'b1;
        end
      end
      if (frm_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic set_rd(input int r);
    rd_int = r;
    rd_ptr = 10'(r);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < DEPTH; i++) wr_seen[i] = 1'b0;
  endtask

  task automatic seq_fill(input int len);
    for (int i = 0; i < len; i++) fbytes[i] = 8'(i);
  endtask

  task automatic rand_fill(input int len);
    for (int i = 0; i < len; i++) fbytes[i] = 8'($urandom);
  endtask

  function automatic logic [31:0] pack(input int i, input int len);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++)
      if (4 * i + b < len) w[8*b +: 8] = fbytes[4*i+b];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_cew", ram_cew, 0);
    chk("rst_aw", ram_aw, 0);
    chk("rst_dw", ram_dw, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_done", frm_done, 0);
    chk("rst_len", frm_len, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 0; m_drop = 0; m_done = 0; done_cnt = 0;
  endtask

  task automatic drive_frame(input int len, input bit err, input bit with_eof, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        rx_sof   = 1'($urandom);
        rx_eof   = 1'($urandom);
        rx_err   = 1'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = fbytes[i];
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == len - 1);
      rx_err   = rx_eof ? err : 1'($urandom);
      if (rx_eof) last_eof = cyc;
      @(negedge clk);
    end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
  endtask

  // Model: a frame commits only if it fits, no data word lands on rd, and it is not an errored frame being dropped.
  task automatic check_frame(input int len, input bit err, input int eof_c);
    int nw, k;
    bit ovf, commit;
    logic [31:0] hdr;
    nw = (len + 3) / 4;
    ovf = 1'b0;
    k = nw;
    for (int i = 0; i < nw; i++)
      if (!ovf && ((m_wr + 1 + i) % DEPTH) == rd_int) begin ovf = 1'b1; k = i; end
    commit = !ovf && (len <= MAXB) && !(err && !KEEP);
    if (rd_int != m_wr) chk("no_wr_at_rd", wr_seen[rd_int], 0);
    if (commit) begin
      for (int i = 0; i < nw; i++) begin
        chk("data_seen", wr_seen[(m_wr + 1 + i) % DEPTH], 1);
        chk("data", mem_img[(m_wr + 1 + i) % DEPTH], pack(i, len));
      end
      hdr = 32'(len) | ((err && KEEP) ? 32'h0001_0000 : 32'h0);
      chk("header", mem_img[m_wr], hdr);
      m_wr = (m_wr + 1 + nw) % DEPTH;
      m_done++;
      chk("frm_len", frm_len, len);
      chk("latency", done_cyc, eof_c + 3);
    end else begin
      m_drop++;
      if (ovf && len <= MAXB)
        for (int i = 0; i < k; i++) chk("pre_ovf_data", mem_img[(m_wr + 1 + i) % DEPTH], pack(i, len));
    end
    chk("wr_ptr", wr_ptr, m_wr);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("done_cnt", done_cnt, m_done);
  endtask

  task automatic run_frame(input int len, input bit err, input int gap, input int rd);
    set_rd(rd);
    clear_seen();
    drive_frame(len, err, 1'b1, gap);
    repeat (6) @(negedge clk);
    check_frame(len, err, last_eof);
  endtask

  initial begin
    int d, words, len, mode, eof1;
    rst_n = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0;
    rx_data = '0; set_rd(0);
    for (int i = 0; i < DEPTH; i++) mem_img[i] = '0;
    do_reset();

    // 64 sequential bytes into an empty ring at 0
    seq_fill(64);
    run_frame(64, 1'b0, 0, 0);
    chk("t1_addr1", mem_img[1], 32'h03020100);
    chk("t1_addr16", mem_img[16], 32'h3F3E3D3C);
    chk("t1_hdr", mem_img[0], 32'h00000040);
    chk("t1_wr_ptr", wr_ptr, 17);
    chk("t1_len", frm_len, 64);

    // 61-byte frame: partial final word
    do_reset();
    set_rd(0);
    seq_fill(61);
    run_frame(61, 1'b0, 0, 0);
    chk("t2_addr16", mem_img[16], 32'h0000003C);
    chk("t2_hdr", mem_img[0], 32'h0000003D);
    chk("t2_wr_ptr", wr_ptr, 17);

    // Random frames, mostly into an empty ring, some against a nearby reader
    for (int n = 0; n < 12; n++) begin
      len  = $urandom_range(1, 200);
      mode = $urandom_range(0, 3);
      rand_fill(len);
      run_frame(len, ($urandom_range(0, 7) == 0), 25,
                (mode < 3) ? m_wr : (m_wr + $urandom_range(1, 60)) % DEPTH);
    end

    // Walk the ring to 760, then a wrapping frame
    while (m_wr != 760) begin
      d = (760 - m_wr + DEPTH) % DEPTH;
      words = (d > 385) ? ((d - 385 < 2) ? 300 : 385) : ((d < 2) ? 300 : d);
      len = 4 * (words - 1);
      rand_fill(len);
      run_frame(len, 1'b0, 0, m_wr);
    end
    seq_fill(64);
    run_frame(64, 1'b0, 10, 760);
    chk("t3_hdr", mem_img[760], 32'h00000040);
    chk("t3_addr767", mem_img[767], 32'h1B1A1918);
    chk("t3_addr0", mem_img[0], 32'h1F1E1D1C);
    chk("t3_wr_ptr", wr_ptr, 9);

    // Overflow against rd=10, then a normal frame once rd moves
    do_reset();
    seq_fill(64);
    run_frame(64, 1'b0, 0, 10);
    chk("t4_no_addr10", wr_seen[10], 0);
    chk("t4_addr9", wr_seen[9], 1);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_wr_ptr", wr_ptr, 0);
    rand_fill(16);
    run_frame(16, 1'b0, 0, 0);
    chk("t4b_wr_ptr", wr_ptr, 5);

    // Errored frame
    seq_fill(64);
    run_frame(64, 1'b1, 0, m_wr);

    // New sof in the flush cycle: first frame commits, second is dropped
    set_rd(m_wr);
    clear_seen();
    rand_fill(8);
    drive_frame(8, 1'b0, 1'b1, 0);
    eof1 = last_eof;
    drive_frame(4, 1'b0, 1'b1, 0);
    repeat (6) @(negedge clk);
    m_drop++;
    check_frame(8, 1'b0, eof1);

    // Missing eof: sof mid-frame drops the old frame and restarts
    set_rd(m_wr);
    clear_seen();
    rand_fill(10);
    drive_frame(10, 1'b0, 1'b0, 0);
    rand_fill(8);
    drive_frame(8, 1'b0, 1'b1, 0);
    repeat (6) @(negedge clk);
    m_drop++;
    check_frame(8, 1'b0, last_eof);

    // Oversize frame
    rand_fill(1537);
    run_frame(1537, 1'b0, 0, m_wr);

    // Reset mid-frame, then a clean frame from address 0
    set_rd(m_wr);
    rand_fill(20);
    drive_frame(20, 1'b0, 1'b0, 0);
    do_reset();
    set_rd(0);
    rand_fill(32);
    run_frame(32, 1'b0, 0, 0);
    chk("t6_wr_ptr", wr_ptr, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
